// File: rtl/atm_txn_controller.sv
`default_nettype none
// ============================================================================
// Module   : atm_txn_controller
// Purpose  : Multi-account ATM transaction sequencer. Handles card insertion,
//            PIN check with per-account lockout, and balance, withdraw,
//            deposit, transfer and PIN-change transactions with an optional
//            receipt. Holds the balance, PIN and lock register files.
// Ports    : clk, reset (async, active-high)
//            card_valid/card_acct   - card insertion and account on the card
//            pin_valid/pin          - entered PIN, or new PIN in PINCHG
//            op_valid/opcode        - 0 eject,1 bal,2 wdraw,3 dep,4 xfer,5 pinchg
//            amt_valid/amount/dst_acct - transaction amount and xfer target
//            rcpt_valid/take_receipt   - receipt choice
//            state_o, balance_o, err_o - status (all registered)
//            dispense_o/dispense_amt, print_o, eject_o, retain_o - pulses
// Options  : ATM_IDLE_TIMEOUT_EN - build the idle-timeout counter
//            (TIMEOUT_CYC cycles without a strobe -> EJECT with err 7)
// Revision : 1.0 - initial release
// ============================================================================
module atm_txn_controller #(
  parameter int               AMT_W       = 32,
  parameter int               PIN_W       = 16,
  parameter int               NUM_ACCTS   = 4,
  parameter int               MAX_TRIES   = 3,
  parameter logic [AMT_W-1:0] INIT_BAL    = AMT_W'(100000),
  parameter logic [PIN_W-1:0] INIT_PIN    = PIN_W'(16'h1234),
  parameter int               TIMEOUT_CYC = 1024,
  localparam int              AW          = (NUM_ACCTS > 1) ? $clog2(NUM_ACCTS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             card_valid,
  input  logic [AW-1:0]    card_acct,
  input  logic             pin_valid,
  input  logic [PIN_W-1:0] pin,
  input  logic             op_valid,
  input  logic [2:0]       opcode,
  input  logic             amt_valid,
  input  logic [AMT_W-1:0] amount,
  input  logic [AW-1:0]    dst_acct,
  input  logic             rcpt_valid,
  input  logic             take_receipt,
  output logic [3:0]       state_o,
  output logic [AMT_W-1:0] balance_o,
  output logic             dispense_o,
  output logic [AMT_W-1:0] dispense_amt,
  output logic             print_o,
  output logic             eject_o,
  output logic             retain_o,
  output logic [2:0]       err_o
);

  localparam int TRW = $clog2(MAX_TRIES + 1);

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_PIN     = 3'd1;
  localparam logic [2:0] ERR_LOCKED  = 3'd2;
  localparam logic [2:0] ERR_FUNDS   = 3'd3;
  localparam logic [2:0] ERR_OVF     = 3'd4;
  localparam logic [2:0] ERR_DST     = 3'd5;
  localparam logic [2:0] ERR_ZERO    = 3'd6;
  localparam logic [2:0] ERR_TIMEOUT = 3'd7;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_PIN     = 4'd1,
    S_HOME    = 4'd2,
    S_BAL     = 4'd3,
    S_WDRAW   = 4'd4,
    S_DEP     = 4'd5,
    S_XFER    = 4'd6,
    S_PINCHG  = 4'd7,
    S_RECEIPT = 4'd8,
    S_PRINT   = 4'd9,
    S_EJECT   = 4'd10,
    S_RETAIN  = 4'd11
  } state_t;

  state_t state, state_nxt;

  // Register files
  logic [AMT_W-1:0]     bal  [NUM_ACCTS];
  logic [PIN_W-1:0]     pins [NUM_ACCTS];
  logic [NUM_ACCTS-1:0] locked;
  logic [AW-1:0]        active;
  logic [TRW-1:0]       tries;

  // Next-state / control from the combinational process
  logic [AW-1:0]    active_nxt;
  logic [TRW-1:0]   tries_nxt;
  logic [2:0]       err_nxt;
  logic             lock_set, pin_wr, src_wr, dst_wr, dispense_nxt;
  logic [AMT_W-1:0] src_val, dst_val;
  logic             timeout_hit;

  // Datapath helpers
  logic             card_ok, dst_ok;
  logic [AMT_W-1:0] src_bal, dst_bal;
  logic [AMT_W:0]   dep_sum, xfer_sum;

  assign card_ok  = (int'(card_acct) < NUM_ACCTS);
  // A transfer to self is rejected along with out-of-range targets.
  assign dst_ok   = (int'(dst_acct) < NUM_ACCTS) && (dst_acct != active);
  assign src_bal  = bal[active];
  assign dst_bal  = bal[dst_acct];
  assign dep_sum  = {1'b0, src_bal} + {1'b0, amount};
  assign xfer_sum = {1'b0, dst_bal} + {1'b0, amount};

  assign state_o  = state;

`ifdef ATM_IDLE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] idle_cnt;
  logic          waiting, any_strobe;

  assign waiting    = (state == S_PIN)   || (state == S_HOME) || (state == S_WDRAW) ||
                      (state == S_DEP)   || (state == S_XFER) || (state == S_PINCHG) ||
                      (state == S_RECEIPT);
  assign any_strobe = card_valid | pin_valid | op_valid | amt_valid | rcpt_valid;
  // Fires on the last of TIMEOUT_CYC strobe-free cycles spent in one state.
  assign timeout_hit = waiting && !any_strobe && (idle_cnt == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idle_cnt <= '0;
    end else if (!waiting || any_strobe || (state_nxt != state)) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + TW'(1);
    end
  end
`else
  // Timeout not built: constant false (TIMEOUT_CYC is never negative).
  assign timeout_hit = (TIMEOUT_CYC < 0);
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state and transaction decisions
  always_comb begin
    state_nxt    = state;
    active_nxt   = active;
    tries_nxt    = tries;
    err_nxt      = err_o;
    lock_set     = 1'b0;
    pin_wr       = 1'b0;
    src_wr       = 1'b0;
    dst_wr       = 1'b0;
    dispense_nxt = 1'b0;
    src_val      = src_bal;
    dst_val      = dst_bal;

    case (state)
      S_IDLE: if (card_valid) begin
        active_nxt = card_acct;
        tries_nxt  = '0;
        err_nxt    = ERR_NONE;
        // An account number beyond NUM_ACCTS is treated like a locked card.
        if (!card_ok || locked[card_acct]) begin
          state_nxt = S_RETAIN;
          err_nxt   = ERR_LOCKED;
        end else begin
          state_nxt = S_PIN;
        end
      end
      S_PIN: if (pin_valid) begin
        err_nxt = ERR_NONE;
        if (pin == pins[active]) begin
          state_nxt = S_HOME;
        end else begin
          tries_nxt = tries + TRW'(1);
          err_nxt   = ERR_PIN;
          if ((int'(tries) + 1) >= MAX_TRIES) begin
            lock_set  = 1'b1;
            err_nxt   = ERR_LOCKED;
            state_nxt = S_RETAIN;
          end
        end
      end
      S_HOME: if (op_valid) begin
        err_nxt = ERR_NONE;
        case (opcode)
          3'd0:    state_nxt = S_EJECT;
          3'd1:    state_nxt = S_BAL;
          3'd2:    state_nxt = S_WDRAW;
          3'd3:    state_nxt = S_DEP;
          3'd4:    state_nxt = S_XFER;
          3'd5:    state_nxt = S_PINCHG;
          default: state_nxt = S_HOME;
        endcase
      end
      S_BAL: state_nxt = S_RECEIPT;
      S_WDRAW: if (amt_valid) begin
        err_nxt   = ERR_NONE;
        state_nxt = S_HOME;
        if (amount == '0) begin
          err_nxt = ERR_ZERO;
        end else if (amount > src_bal) begin
          err_nxt = ERR_FUNDS;
        end else begin
          src_wr       = 1'b1;
          src_val      = src_bal - amount;
          dispense_nxt = 1'b1;
          state_nxt    = S_RECEIPT;
        end
      end
      S_DEP: if (amt_valid) begin
        err_nxt   = ERR_NONE;
        state_nxt = S_HOME;
        if (amount == '0) begin
          err_nxt = ERR_ZERO;
        end else if (dep_sum[AMT_W]) begin
          err_nxt = ERR_OVF;
        end else begin
          src_wr    = 1'b1;
          src_val   = dep_sum[AMT_W-1:0];
          state_nxt = S_RECEIPT;
        end
      end
      S_XFER: if (amt_valid) begin
        err_nxt   = ERR_NONE;
        state_nxt = S_HOME;
        if (!dst_ok) begin
          err_nxt = ERR_DST;
        end else if (amount == '0) begin
          err_nxt = ERR_ZERO;
        end else if (amount > src_bal) begin
          err_nxt = ERR_FUNDS;
        end else if (xfer_sum[AMT_W]) begin
          err_nxt = ERR_OVF;
        end else begin
          // Debit and credit commit on the same edge; dst != active here.
          src_wr    = 1'b1;
          src_val   = src_bal - amount;
          dst_wr    = 1'b1;
          dst_val   = xfer_sum[AMT_W-1:0];
          state_nxt = S_RECEIPT;
        end
      end
      S_PINCHG: if (pin_valid) begin
        err_nxt   = ERR_NONE;
        pin_wr    = 1'b1;
        state_nxt = S_HOME;
      end
      S_RECEIPT: if (rcpt_valid) begin
        err_nxt   = ERR_NONE;
        state_nxt = take_receipt ? S_PRINT : S_HOME;
      end
      S_PRINT:  state_nxt = S_HOME;
      S_EJECT:  state_nxt = S_IDLE;
      S_RETAIN: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase

    // Only reachable when no strobe arrived this cycle.
    if (timeout_hit) begin
      state_nxt = S_EJECT;
      err_nxt   = ERR_TIMEOUT;
    end
  end

  // Register files
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_ACCTS; i++) begin
        bal[i]  <= INIT_BAL;
        pins[i] <= INIT_PIN;
      end
      locked <= '0;
    end else begin
      if (src_wr)   bal[active]    <= src_val;
      if (dst_wr)   bal[dst_acct]  <= dst_val;
      if (pin_wr)   pins[active]   <= pin;
      if (lock_set) locked[active] <= 1'b1;
    end
  end

  // Session registers and outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active       <= '0;
      tries        <= '0;
      err_o        <= ERR_NONE;
      balance_o    <= '0;
      dispense_o   <= 1'b0;
      dispense_amt <= '0;
      print_o      <= 1'b0;
      eject_o      <= 1'b0;
      retain_o     <= 1'b0;
    end else begin
      active       <= active_nxt;
      tries        <= tries_nxt;
      err_o        <= err_nxt;
      dispense_o   <= dispense_nxt;
      dispense_amt <= dispense_nxt ? amount : '0;
      // Pulses coincide with the one-cycle state they announce.
      print_o      <= (state_nxt == S_PRINT);
      eject_o      <= (state_nxt == S_EJECT);
      retain_o     <= (state_nxt == S_RETAIN);
      if ((state_nxt == S_BAL) || (state_nxt == S_RECEIPT)) begin
        balance_o <= src_wr ? src_val : src_bal;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_atm_txn_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_atm_txn_controller
// Purpose  : Self-checking bench for atm_txn_controller. Keeps a per-account
//            model (balances, PINs, locks) and predicts state, error code,
//            balance and pulses for directed and randomized transactions.
// Options  : ATM_IDLE_TIMEOUT_EN - also exercises the idle timeout (16 cycles)
// Revision : 1.0 - initial release
// ============================================================================
module tb_atm_txn_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        card_valid = 1'b0, pin_valid = 1'b0, op_valid = 1'b0;
  logic        amt_valid = 1'b0, rcpt_valid = 1'b0, take_receipt = 1'b0;
  logic [1:0]  card_acct = '0, dst_acct = '0;
  logic [15:0] pin = '0;
  logic [2:0]  opcode = '0;
  logic [31:0] amount = '0;
  logic [3:0]  state_o;
  logic [31:0] balance_o, dispense_amt;
  logic        dispense_o, print_o, eject_o, retain_o;
  logic [2:0]  err_o;

  int checks = 0;
  int failures = 0;

  // Reference model
  logic [31:0] mbal [4];
  logic [15:0] mpin [4];
  bit          mlock[4];

  always #5 clk = ~clk;

  atm_txn_controller #(
    .AMT_W(32), .PIN_W(16), .NUM_ACCTS(4), .MAX_TRIES(3),
    .INIT_BAL(32'd100000), .INIT_PIN(16'h1234), .TIMEOUT_CYC(16)
  ) dut (
    .clk(clk), .reset(reset),
    .card_valid(card_valid), .card_acct(card_acct),
    .pin_valid(pin_valid), .pin(pin),
    .op_valid(op_valid), .opcode(opcode),
    .amt_valid(amt_valid), .amount(amount), .dst_acct(dst_acct),
    .rcpt_valid(rcpt_valid), .take_receipt(take_receipt),
    .state_o(state_o), .balance_o(balance_o),
    .dispense_o(dispense_o), .dispense_amt(dispense_amt),
    .print_o(print_o), .eject_o(eject_o), .retain_o(retain_o), .err_o(err_o)
  );

  task automatic model_reset;
    for (int i = 0; i < 4; i++) begin
      mbal[i]  = 32'd100000;
      mpin[i]  = 16'h1234;
      mlock[i] = 1'b0;
    end
  endtask

  // Stimulus drivers: strobe set at negedge, consumed at posedge, sampled #1 later
  task automatic step_idle;
    @(posedge clk); #1;
  endtask
  task automatic step_card(input logic [1:0] a);
    @(negedge clk); card_valid = 1'b1; card_acct = a;
    @(posedge clk); #1; card_valid = 1'b0;
  endtask
  task automatic step_pin(input logic [15:0] p);
    @(negedge clk); pin_valid = 1'b1; pin = p;
    @(posedge clk); #1; pin_valid = 1'b0;
  endtask
  task automatic step_op(input logic [2:0] o);
    @(negedge clk); op_valid = 1'b1; opcode = o;
    @(posedge clk); #1; op_valid = 1'b0;
  endtask
  task automatic step_amt(input logic [31:0] a, input logic [1:0] d);
    @(negedge clk); amt_valid = 1'b1; amount = a; dst_acct = d;
    @(posedge clk); #1; amt_valid = 1'b0;
  endtask
  task automatic step_rcpt(input logic t);
    @(negedge clk); rcpt_valid = 1'b1; take_receipt = t;
    @(posedge clk); #1; rcpt_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    checks++; if (state_o !== 4'd0) begin failures++; $display("FAIL reset_state: got %0d exp 0", state_o); end
    checks++; if (err_o !== 3'd0) begin failures++; $display("FAIL reset_err: got %0d exp 0", err_o); end
    checks++; if (balance_o !== 32'd0 || dispense_amt !== 32'd0) begin failures++; $display("FAIL reset_data: bal %0d amt %0d exp 0 0", balance_o, dispense_amt); end
    checks++; if ({dispense_o, print_o, eject_o, retain_o} !== 4'b0) begin failures++; $display("FAIL reset_pulses: got %b exp 0000", {dispense_o, print_o, eject_o, retain_o}); end
    reset = 1'b0;
  endtask

  task automatic test_balance_receipt;
    step_card(2'd1);
    checks++; if (state_o !== 4'd1) begin failures++; $display("FAIL bal_pin_state: got %0d exp 1", state_o); end
    step_pin(16'h1234);
    checks++; if (state_o !== 4'd2) begin failures++; $display("FAIL bal_home_state: got %0d exp 2", state_o); end
    step_op(3'd1);
    checks++; if (state_o !== 4'd3 || balance_o !== mbal[1]) begin failures++; $display("FAIL bal_show: state %0d bal %0d exp 3 %0d", state_o, balance_o, mbal[1]); end
    step_idle();
    checks++; if (state_o !== 4'd8) begin failures++; $display("FAIL bal_receipt_state: got %0d exp 8", state_o); end
    step_rcpt(1'b1);
    checks++; if (state_o !== 4'd9 || print_o !== 1'b1) begin failures++; $display("FAIL bal_print: state %0d print %0d exp 9 1", state_o, print_o); end
    step_idle();
    checks++; if (state_o !== 4'd2 || print_o !== 1'b0) begin failures++; $display("FAIL bal_after_print: state %0d print %0d exp 2 0", state_o, print_o); end
    step_op(3'd0);
    checks++; if (state_o !== 4'd10 || eject_o !== 1'b1) begin failures++; $display("FAIL bal_eject: state %0d eject %0d exp 10 1", state_o, eject_o); end
    step_idle();
    checks++; if (state_o !== 4'd0 || eject_o !== 1'b0) begin failures++; $display("FAIL bal_idle: state %0d eject %0d exp 0 0", state_o, eject_o); end
  endtask

  task automatic test_lockout;
    logic [15:0] wp;
    step_card(2'd2);
    for (int k = 0; k < 3; k++) begin
      wp = mpin[2] ^ 16'($urandom_range(1, 65535));
      step_pin(wp);
      if (k < 2) begin
        checks++; if (state_o !== 4'd1 || err_o !== 3'd1) begin failures++; $display("FAIL lock_try%0d: state %0d err %0d exp 1 1", k, state_o, err_o); end
      end else begin
        checks++; if (state_o !== 4'd11 || retain_o !== 1'b1 || err_o !== 3'd2) begin failures++; $display("FAIL lock_retain: state %0d retain %0d err %0d exp 11 1 2", state_o, retain_o, err_o); end
      end
    end
    mlock[2] = 1'b1;
    step_idle();
    checks++; if (state_o !== 4'd0 || retain_o !== 1'b0) begin failures++; $display("FAIL lock_idle: state %0d retain %0d exp 0 0", state_o, retain_o); end
    step_card(2'd2);
    checks++; if (state_o !== 4'd11 || err_o !== 3'd2) begin failures++; $display("FAIL lock_reinsert: state %0d err %0d exp 11 2", state_o, err_o); end
    step_idle();
  endtask

  // Leaves account 0 in HOME for the transfer test
  task automatic test_withdraw;
    step_card(2'd0);
    step_pin(mpin[0]);
    step_op(3'd2);
    checks++; if (state_o !== 4'd4) begin failures++; $display("FAIL wd_state: got %0d exp 4", state_o); end
    step_amt(mbal[0] + 32'd1, 2'd0);
    checks++; if (state_o !== 4'd2 || err_o !== 3'd3) begin failures++; $display("FAIL wd_insufficient: state %0d err %0d exp 2 3", state_o, err_o); end
    step_op(3'd2);
    step_amt(32'd0, 2'd0);
    checks++; if (state_o !== 4'd2 || err_o !== 3'd6) begin failures++; $display("FAIL wd_zero: state %0d err %0d exp 2 6", state_o, err_o); end
    step_op(3'd2);
    step_amt(32'd40000, 2'd0);
    mbal[0] = mbal[0] - 32'd40000;
    checks++; if (state_o !== 4'd8 || dispense_o !== 1'b1 || dispense_amt !== 32'd40000) begin failures++; $display("FAIL wd_dispense: state %0d disp %0d amt %0d exp 8 1 40000", state_o, dispense_o, dispense_amt); end
    checks++; if (balance_o !== mbal[0] || err_o !== 3'd0) begin failures++; $display("FAIL wd_balance: bal %0d err %0d exp %0d 0", balance_o, err_o, mbal[0]); end
    step_rcpt(1'b0);
    checks++; if (state_o !== 4'd2 || dispense_o !== 1'b0) begin failures++; $display("FAIL wd_home: state %0d disp %0d exp 2 0", state_o, dispense_o); end
  endtask

  task automatic test_transfer;
    step_op(3'd4);
    step_amt(32'd30000, 2'd3);
    mbal[0] = mbal[0] - 32'd30000;
    mbal[3] = mbal[3] + 32'd30000;
    checks++; if (state_o !== 4'd8 || balance_o !== mbal[0]) begin failures++; $display("FAIL xfer_src: state %0d bal %0d exp 8 %0d", state_o, balance_o, mbal[0]); end
    step_rcpt(1'b0);
    step_op(3'd4);
    step_amt(32'd100, 2'd0);
    checks++; if (state_o !== 4'd2 || err_o !== 3'd5) begin failures++; $display("FAIL xfer_self: state %0d err %0d exp 2 5", state_o, err_o); end
    step_op(3'd3);
    step_amt(32'hFFFF_FFFF, 2'd0);
    checks++; if (state_o !== 4'd2 || err_o !== 3'd4) begin failures++; $display("FAIL dep_overflow: state %0d err %0d exp 2 4", state_o, err_o); end
    step_op(3'd0);
    step_idle();
    step_card(2'd3);
    step_pin(mpin[3]);
    step_op(3'd1);
    checks++; if (balance_o !== mbal[3]) begin failures++; $display("FAIL xfer_dst: bal %0d exp %0d", balance_o, mbal[3]); end
    step_idle();
    step_rcpt(1'b0);
    step_op(3'd0);
    step_idle();
  endtask

  task automatic test_pin_change;
    step_card(2'd0);
    step_pin(mpin[0]);
    step_op(3'd5);
    checks++; if (state_o !== 4'd7) begin failures++; $display("FAIL pinchg_state: got %0d exp 7", state_o); end
    step_pin(16'h4321);
    mpin[0] = 16'h4321;
    checks++; if (state_o !== 4'd2) begin failures++; $display("FAIL pinchg_home: got %0d exp 2", state_o); end
    step_op(3'd0);
    step_idle();
    step_card(2'd0);
    step_pin(16'h1234);
    checks++; if (state_o !== 4'd1 || err_o !== 3'd1) begin failures++; $display("FAIL pinchg_old: state %0d err %0d exp 1 1", state_o, err_o); end
    step_pin(mpin[0]);
    checks++; if (state_o !== 4'd2 || err_o !== 3'd0) begin failures++; $display("FAIL pinchg_new: state %0d err %0d exp 2 0", state_o, err_o); end
    step_op(3'd0);
    step_idle();
  endtask

  // All strobes at once: only the one for the current state is used
  task automatic test_simultaneous;
    step_card(2'd1);
    step_pin(mpin[1]);
    @(negedge clk);
    op_valid = 1'b1; opcode = 3'd2; amt_valid = 1'b1; amount = 32'd5;
    pin_valid = 1'b1; pin = 16'h0000; rcpt_valid = 1'b1; take_receipt = 1'b1;
    @(posedge clk); #1;
    {op_valid, amt_valid, pin_valid, rcpt_valid} = 4'b0;
    checks++; if (state_o !== 4'd4 || dispense_o !== 1'b0) begin failures++; $display("FAIL simul_home: state %0d disp %0d exp 4 0", state_o, dispense_o); end
    step_amt(32'd5, 2'd0);
    mbal[1] = mbal[1] - 32'd5;
    checks++; if (state_o !== 4'd8 || balance_o !== mbal[1]) begin failures++; $display("FAIL simul_wd: state %0d bal %0d exp 8 %0d", state_o, balance_o, mbal[1]); end
    step_amt(32'd7, 2'd0);
    checks++; if (state_o !== 4'd8 || dispense_o !== 1'b0) begin failures++; $display("FAIL simul_ignore: state %0d disp %0d exp 8 0", state_o, dispense_o); end
    step_rcpt(1'b0);
    step_op(3'd0);
    step_idle();
  endtask

  task automatic test_random;
    logic [1:0]  a, dst;
    logic [2:0]  op, exp_err;
    logic [3:0]  exp_state;
    logic [31:0] amt;
    bit          exp_disp, take;
    for (int s = 0; s < 6; s++) begin
      do a = 2'($urandom_range(0, 3)); while (mlock[a]);
      step_card(a);
      step_pin(mpin[a]);
      checks++; if (state_o !== 4'd2) begin failures++; $display("FAIL rnd_login: acct %0d state %0d exp 2", a, state_o); end
      for (int t = 0; t < 8; t++) begin
        op  = 3'($urandom_range(1, 4));
        dst = 2'($urandom_range(0, 3));
        case ($urandom_range(0, 3))
          0:       amt = 32'd0;
          1:       amt = 32'($urandom_range(1, 20000));
          2:       amt = mbal[a] + 32'($urandom_range(1, 1000));
          default: amt = 32'hFFFF_FFFF - 32'($urandom_range(0, 1000));
        endcase
        exp_state = 4'd2; exp_err = 3'd0; exp_disp = 1'b0;
        step_op(op);
        if (op == 3'd1) begin
          checks++; if (state_o !== 4'd3 || balance_o !== mbal[a]) begin failures++; $display("FAIL rnd_bal: state %0d bal %0d exp 3 %0d", state_o, balance_o, mbal[a]); end
          step_idle();
          exp_state = 4'd8;
        end else begin
          checks++; if (state_o !== 4'(op) + 4'd2) begin failures++; $display("FAIL rnd_opsel: op %0d state %0d exp %0d", op, state_o, op + 2); end
          step_amt(amt, dst);
          if (op == 3'd2) begin
            if (amt == 0) exp_err = 3'd6;
            else if (amt > mbal[a]) exp_err = 3'd3;
            else begin mbal[a] = mbal[a] - amt; exp_state = 4'd8; exp_disp = 1'b1; end
          end else if (op == 3'd3) begin
            if (amt == 0) exp_err = 3'd6;
            else if ({1'b0, mbal[a]} + {1'b0, amt} > 33'h0_FFFF_FFFF) exp_err = 3'd4;
            else begin mbal[a] = mbal[a] + amt; exp_state = 4'd8; end
          end else begin
            if (dst == a) exp_err = 3'd5;
            else if (amt == 0) exp_err = 3'd6;
            else if (amt > mbal[a]) exp_err = 3'd3;
            else if ({1'b0, mbal[dst]} + {1'b0, amt} > 33'h0_FFFF_FFFF) exp_err = 3'd4;
            else begin mbal[a] = mbal[a] - amt; mbal[dst] = mbal[dst] + amt; exp_state = 4'd8; end
          end
          checks++; if (state_o !== exp_state || err_o !== exp_err) begin failures++; $display("FAIL rnd_txn: op %0d amt %0d state %0d err %0d exp %0d %0d", op, amt, state_o, err_o, exp_state, exp_err); end
          checks++; if (dispense_o !== exp_disp || (exp_disp && dispense_amt !== amt)) begin failures++; $display("FAIL rnd_dispense: disp %0d amt %0d exp %0d %0d", dispense_o, dispense_amt, exp_disp, amt); end
        end
        if (exp_state == 4'd8) begin
          checks++; if (state_o !== 4'd8 || balance_o !== mbal[a]) begin failures++; $display("FAIL rnd_receipt: state %0d bal %0d exp 8 %0d", state_o, balance_o, mbal[a]); end
          take = 1'($urandom_range(0, 1));
          step_rcpt(take);
          if (take) begin
            checks++; if (print_o !== 1'b1) begin failures++; $display("FAIL rnd_print: print %0d exp 1", print_o); end
            step_idle();
          end
          checks++; if (state_o !== 4'd2) begin failures++; $display("FAIL rnd_home: state %0d exp 2", state_o); end
        end
      end
      step_op(3'd0);
      checks++; if (eject_o !== 1'b1) begin failures++; $display("FAIL rnd_eject: eject %0d exp 1", eject_o); end
      step_idle();
    end
  endtask

`ifdef ATM_IDLE_TIMEOUT_EN
  task automatic test_timeout;
    step_card(2'd1);
    step_pin(mpin[1]);
    repeat (15) step_idle();
    checks++; if (state_o !== 4'd2) begin failures++; $display("FAIL to_early: state %0d exp 2", state_o); end
    step_idle();
    checks++; if (state_o !== 4'd10 || eject_o !== 1'b1 || err_o !== 3'd7) begin failures++; $display("FAIL to_eject: state %0d eject %0d err %0d exp 10 1 7", state_o, eject_o, err_o); end
    step_idle();
  endtask
`endif

  task automatic test_reset_mid;
    step_card(2'd0);
    step_pin(mpin[0]);
    step_op(3'd4);
    checks++; if (state_o !== 4'd6) begin failures++; $display("FAIL rst_xfer_state: got %0d exp 6", state_o); end
    @(negedge clk); #2 reset = 1'b1; #1;
    checks++; if (state_o !== 4'd0) begin failures++; $display("FAIL rst_async: state %0d exp 0", state_o); end
    @(negedge clk); reset = 1'b0;
    model_reset();
    step_card(2'd2);
    checks++; if (state_o !== 4'd1) begin failures++; $display("FAIL rst_unlock: state %0d exp 1", state_o); end
    step_pin(16'h1234);
    step_op(3'd1);
    checks++; if (balance_o !== mbal[2]) begin failures++; $display("FAIL rst_balance: bal %0d exp %0d", balance_o, mbal[2]); end
    step_idle();
    step_rcpt(1'b0);
    step_op(3'd0);
    step_idle();
    step_card(2'd0);
    step_pin(16'h1234);
    step_op(3'd1);
    checks++; if (state_o !== 4'd3 || balance_o !== mbal[0]) begin failures++; $display("FAIL rst_acct0: state %0d bal %0d exp 3 %0d", state_o, balance_o, mbal[0]); end
  endtask

  initial begin
    test_reset();
    test_balance_receipt();
    test_lockout();
    test_withdraw();
    test_transfer();
    test_pin_change();
    test_simultaneous();
    test_random();
`ifdef ATM_IDLE_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
